// File: rtl/reg_file_pkg.sv
// Shared defaults for the register file: data/address widths and the
// write-counter width with its saturation value.
package reg_file_pkg;
  localparam int WIDTH_DEF  = 16;
  localparam int ADDR_W_DEF = 3;
  localparam int CNT_W      = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
endpackage

// File: rtl/reg_file_if.sv
// Write/read bus of the register file; master drives requests, slave returns
// registered read data and the accepted-write count.
interface reg_file_if
  import reg_file_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic              ren_a;
  logic [ADDR_W-1:0] raddr_a;
  logic [WIDTH-1:0]  rdata_a;
  logic              ren_b;
  logic [ADDR_W-1:0] raddr_b;
  logic [WIDTH-1:0]  rdata_b;
  logic [CNT_W-1:0]  wr_cnt;

  modport master (
    output we, waddr, wdata, ren_a, raddr_a, ren_b, raddr_b,
    input  rdata_a, rdata_b, wr_cnt
  );

  modport slave (
    input  we, waddr, wdata, ren_a, raddr_a, ren_b, raddr_b,
    output rdata_a, rdata_b, wr_cnt
  );
endinterface

// File: rtl/reg_file_reg_w.sv
// Single storage word with load enable and synchronous clear.
module reg_w #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/reg_file.sv
// Two-read/one-write register file with write-first bypass, optional
// hard-zero register 0 and a saturating accepted-write counter.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter bit ZERO_R0 = 1'b1
) (
  input logic         clk,
  input logic         reset,
  reg_file_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] regs [DEPTH];
  logic             wr_ok;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  // A write to the hard-zero register is dropped entirely, including the count.
  assign wr_ok = bus.we && !(ZERO_R0 && (bus.waddr == '0));

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    reg_w #(.WIDTH(WIDTH)) u_reg (
      .clk   (clk),
      .reset (reset),
      .en    (wr_ok && (bus.waddr == ADDR_W'(i))),
      .d     (bus.wdata),
      .q     (regs[i])
    );
  end

  always_comb begin
    rd_a = regs[bus.raddr_a];
    if (ZERO_R0 && (bus.raddr_a == '0))       rd_a = '0;
    else if (wr_ok && (bus.raddr_a == bus.waddr)) rd_a = bus.wdata;
  end

  always_comb begin
    rd_b = regs[bus.raddr_b];
    if (ZERO_R0 && (bus.raddr_b == '0))       rd_b = '0;
    else if (wr_ok && (bus.raddr_b == bus.waddr)) rd_b = bus.wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rdata_a <= '0;
      bus.rdata_b <= '0;
      bus.wr_cnt  <= '0;
    end else begin
      if (bus.ren_a) bus.rdata_a <= rd_a;
      if (bus.ren_b) bus.rdata_b <= rd_b;
      if (wr_ok && (bus.wr_cnt != CNT_MAX)) bus.wr_cnt <= bus.wr_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_reg_file.sv
// Directed bench: two instances (hard-zero r0 on and off) see identical stimulus.
module tb_reg_file;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  reg_file_if #(.WIDTH(16), .ADDR_W(3)) bus1 ();
  reg_file_if #(.WIDTH(16), .ADDR_W(3)) bus0 ();

  reg_file #(.WIDTH(16), .ADDR_W(3), .ZERO_R0(1'b1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  reg_file #(.WIDTH(16), .ADDR_W(3), .ZERO_R0(1'b0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic ea, input logic [2:0] ra,
                       input logic eb, input logic [2:0] rb);
    bus1.we = we; bus1.waddr = wa; bus1.wdata = wd;
    bus1.ren_a = ea; bus1.raddr_a = ra; bus1.ren_b = eb; bus1.raddr_b = rb;
    bus0.we = we; bus0.waddr = wa; bus0.wdata = wd;
    bus0.ren_a = ea; bus0.raddr_a = ra; bus0.ren_b = eb; bus0.raddr_b = rb;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd0);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_rdata_a", bus1.rdata_a, 16'h0);
    check("rst_rdata_b", bus1.rdata_b, 16'h0);
    check("rst_wr_cnt", {8'h0, bus1.wr_cnt}, 16'h0);

    // preload every register, then confirm reset clears them
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 16'h1000 + 16'(i), 1'b0, 3'd0, 1'b0, 3'd0);
      tick();
    end
    idle();
    check("preload_cnt_z1", {8'h0, bus1.wr_cnt}, 16'd7);
    check("preload_cnt_z0", {8'h0, bus0.wr_cnt}, 16'd8);
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 1'b1, 3'd0);
    tick();
    check("preload_rd6", bus1.rdata_a, 16'h1006);
    check("preload_rd0_z1", bus1.rdata_b, 16'h0000);
    check("preload_rd0_z0", bus0.rdata_b, 16'h1000);
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("clr_rdata_a", bus0.rdata_a, 16'h0);
    check("clr_wr_cnt", {8'h0, bus0.wr_cnt}, 16'h0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 1'b1, 3'(7 - i));
      tick();
      check("clr_rd_a_z0", bus0.rdata_a, 16'h0);
      check("clr_rd_b_z0", bus0.rdata_b, 16'h0);
    end

    // write then read one cycle later
    drive(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 1'b0, 3'd0);
    tick();
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 1'b0, 3'd0);
    tick();
    check("wr_rd_3", bus1.rdata_a, 16'hBEEF);
    check("wr_rd_cnt", {8'h0, bus1.wr_cnt}, 16'd1);

    // write-first bypass on both ports
    drive(1'b1, 3'd5, 16'h1111, 1'b0, 3'd0, 1'b0, 3'd0);
    tick();
    drive(1'b1, 3'd5, 16'h2222, 1'b1, 3'd5, 1'b1, 3'd5);
    tick();
    check("byp_a", bus1.rdata_a, 16'h2222);
    check("byp_b", bus1.rdata_b, 16'h2222);
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 1'b1, 3'd3);
    tick();
    check("byp_stored", bus1.rdata_a, 16'h2222);
    check("indep_b", bus1.rdata_b, 16'hBEEF);
    check("byp_cnt", {8'h0, bus1.wr_cnt}, 16'd3);

    // register 0: write with same-edge read, then plain read
    drive(1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 1'b0, 3'd0);
    tick();
    check("r0_byp_z1", bus1.rdata_a, 16'h0000);
    check("r0_byp_z0", bus0.rdata_a, 16'hFFFF);
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 1'b1, 3'd0);
    tick();
    check("r0_rd_z1", bus1.rdata_a, 16'h0000);
    check("r0_rd_z0", bus0.rdata_b, 16'hFFFF);
    check("r0_cnt_z1", {8'h0, bus1.wr_cnt}, 16'd3);
    check("r0_cnt_z0", {8'h0, bus0.wr_cnt}, 16'd4);

    // hold while the register underneath changes
    drive(1'b1, 3'd1, 16'h00AA, 1'b0, 3'd0, 1'b0, 3'd0);
    tick();
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 1'b0, 3'd0);
    tick();
    check("hold_pre", bus1.rdata_a, 16'h00AA);
    drive(1'b1, 3'd1, 16'h5555, 1'b0, 3'd1, 1'b0, 3'd1);
    tick();
    check("hold_a", bus1.rdata_a, 16'h00AA);
    check("hold_b", bus1.rdata_b, 16'h0000);
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 1'b0, 3'd0);
    tick();
    check("hold_post", bus1.rdata_a, 16'h5555);
    check("hold_cnt_z1", {8'h0, bus1.wr_cnt}, 16'd5);
    check("hold_cnt_z0", {8'h0, bus0.wr_cnt}, 16'd6);

    // saturation: dut1 reaches exactly 255 after 250 writes
    for (int i = 0; i < 250; i++) begin
      drive(1'b1, 3'd2, 16'(i), 1'b0, 3'd0, 1'b0, 3'd0);
      tick();
    end
    check("sat_edge_z1", {8'h0, bus1.wr_cnt}, 16'd255);
    for (int i = 250; i < 300; i++) begin
      drive(1'b1, 3'd2, 16'(i), 1'b0, 3'd0, 1'b0, 3'd0);
      tick();
    end
    check("sat_z1", {8'h0, bus1.wr_cnt}, 16'd255);
    check("sat_z0", {8'h0, bus0.wr_cnt}, 16'd255);
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 1'b0, 3'd0);
    tick();
    check("sat_last_data", bus1.rdata_a, 16'd299);

    // reset dominates a concurrent write and read
    drive(1'b1, 3'd2, 16'h0007, 1'b1, 3'd2, 1'b1, 3'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstpri_cnt", {8'h0, bus1.wr_cnt}, 16'd0);
    check("rstpri_rd_a", bus1.rdata_a, 16'h0);
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 1'b0, 3'd0);
    tick();
    check("rstpri_reg2", bus1.rdata_a, 16'h0);
    check("rstpri_cnt2", {8'h0, bus0.wr_cnt}, 16'd0);

    // first operation after reset behaves normally
    drive(1'b1, 3'd4, 16'h1234, 1'b0, 3'd0, 1'b1, 3'd4);
    tick();
    idle();
    check("post_rst_byp", bus1.rdata_b, 16'h1234);
    check("post_rst_cnt", {8'h0, bus1.wr_cnt}, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter WIDTH, 16, data bits per register.
REQ-002 Parameter ADDR_W, 3, address bits; register count DEPTH = 2**ADDR_W.
REQ-003 Parameter ZERO_R0, 1, when 1 register 0 reads as zero and ignores writes.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high; sampled on rising clk edge.
REQ-006 we  input  1  write enable.
REQ-007 waddr  input  ADDR_W  write address.
REQ-008 wdata  input  WIDTH  write data.
REQ-009 ren_a  input  1  read enable, port A.
REQ-010 raddr_a  input  ADDR_W  read address, port A.
REQ-011 rdata_a  output  WIDTH  registered read data, port A.
REQ-012 ren_b  input  1  read enable, port B.
REQ-013 raddr_b  input  ADDR_W  read address, port B.
REQ-014 rdata_b  output  WIDTH  registered read data, port B.
REQ-015 wr_cnt  output  8  saturating count of accepted writes since reset.

Function
REQ-016 Write: we=1 at edge -> reg[waddr] <= wdata; accepted-write count +1.
REQ-017 we=0 -> all registers hold value.
REQ-018 ZERO_R0=1 and waddr=0 -> write dropped, reg[0] stays 0, wr_cnt not incremented.
REQ-019 Read latency 1 cycle: ren_x=1 at edge N -> rdata_x valid after edge N, equal to reg[raddr_x] as of edge N plus bypass.
REQ-020 ren_x=0 -> rdata_x holds previous value (no update).
REQ-021 Bypass: we=1, ren_x=1, raddr_x=waddr same edge -> rdata_x <= wdata (write-first), unless REQ-018 drop applies, then 0.
REQ-022 ZERO_R0=1 and raddr_x=0 -> rdata_x <= 0 regardless of write.
REQ-023 Ports A and B independent; same address on both returns identical data.
REQ-024 wr_cnt saturates at 255; no wrap.
REQ-025 Address width fixes range; no out-of-range case exists.

Reset
REQ-026 reset=1 at edge -> every register, rdata_a, rdata_b, wr_cnt <= 0.
REQ-027 reset dominates we and ren_x same edge; concurrent write discarded, not counted.
REQ-028 Reset mid-operation: first edge with reset=0 behaves as normal operation on zeroed state.
REQ-029 No asynchronous path; before first reset edge outputs undefined.

Structure
REQ-030 Shared package holds default WIDTH, ADDR_W, wr_cnt width (8) and saturation constant.
REQ-031 One sub-module reg_w: WIDTH-bit register with D, en, synchronous reset; DEPTH instances form storage.
REQ-032 Read muxes, bypass compare, output registers and counter in reg_file top.

Verification
REQ-033 Reset: preload all regs, assert reset 1 cycle -> all reads 0, wr_cnt=0.
REQ-034 Write/read: we waddr=3 wdata=16'hBEEF; next cycle ren_a raddr_a=3 -> rdata_a=16'hBEEF one edge later.
REQ-035 Bypass: reg[5]=16'h1111; same edge we waddr=5 wdata=16'h2222, ren_a=ren_b=1 raddr=5 -> both rdata=16'h2222.
REQ-036 R0: ZERO_R0=1, write 16'hFFFF to addr 0, read addr 0 -> 0, wr_cnt unchanged; ZERO_R0=0 -> 16'hFFFF.
REQ-037 Hold: rdata_a=16'h00AA, ren_a=0 while reg changes -> rdata_a stays 16'h00AA.
REQ-038 Saturation and reset priority: 300 writes -> wr_cnt=255; reset with we=1 waddr=2 wdata=7 -> reg[2]=0, wr_cnt=0.
